// File: rtl/apb_master.sv
// apb_master: single-transfer APB initiator with wait-state timeout and saturating error count
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [7:0]            err_count,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int CW = $clog2(TIMEOUT + 2);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          expire;
    // expire marks the TIMEOUT-th ACCESS cycle; PREADY in that same cycle still completes normally
    assign expire    = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
    assign cmd_ready = state == IDLE;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    PADDR  <= cmd_addr;
                    PWRITE <= cmd_write;
                    PWDATA <= cmd_wdata;
                    PSEL   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: if (PREADY || expire) begin
                    rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                    rsp_err     <= PREADY ? PSLVERR : 1'b1;
                    rsp_timeout <= !PREADY;
                    rsp_valid   <= 1'b1;
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    state       <= RESP;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    err_count <= (rsp_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master against a small accumulator register slave
module tb_apb_master;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  err_count;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int total = 0;
    int bad = 0;

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .err_count(err_count),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // slave: 0x00 data, 0x04 control (bit0 adds data into result), 0x08 result (read-only)
    logic [31:0] s_data = '0, s_ctrl = '0, s_res = '0;
    logic [7:0]  acnt = '0, delay = '0;
    logic        hang = 1'b0;
    logic        access;
    assign access  = PSEL && PENABLE;
    assign PREADY  = access && !hang && (acnt >= delay);
    assign PSLVERR = access && ((PADDR[1:0] != 2'b00) || (PADDR > 8'h08) || (PWRITE && PADDR == 8'h08));
    assign PRDATA  = PADDR == 8'h00 ? s_data : PADDR == 8'h04 ? s_ctrl : PADDR == 8'h08 ? s_res : 32'h0;
    always @(posedge PCLK) begin
        acnt <= (access && !PREADY) ? acnt + 8'd1 : 8'd0;
        if (access && PREADY && PWRITE && !PSLVERR) begin
            if (PADDR == 8'h00) s_data <= PWDATA;
            if (PADDR == 8'h04) begin
                s_ctrl <= PWDATA;
                if (PWDATA[0]) s_res <= s_res + s_data;
            end
        end
    end

    logic [31:0] r_rdata;
    logic        r_err, r_tmo, r_psel;
    int          acc;

    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge PCLK); n++; end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        acc = 0; n = 0;
        @(negedge PCLK);
        while (!rsp_valid && n < 100) begin
            if (PSEL && PENABLE) acc++;
            @(negedge PCLK);
            n++;
        end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_wait addr=%h: rsp_valid=%b want 1 within 100 cycles", a, rsp_valid);
        end
        r_rdata = rsp_rdata; r_err = rsp_err; r_tmo = rsp_timeout; r_psel = PSEL;
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 000000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
        end
        total++;
        if (PADDR !== 8'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h %h %h want 0", PADDR, PWDATA, rsp_rdata);
        end
        total++;
        if (err_count !== 8'd0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cnt: err_count=%0d cmd_ready=%b want 0 1", err_count, cmd_ready);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_basic();
        xfer(1'b1, 8'h00, 32'h000000F0);
        total++;
        if (r_err !== 1'b0 || r_rdata !== 32'h0 || acc != 1) begin
            bad++; $display("FAIL wr_data: err=%b rdata=%h acc=%0d want 0 0 1", r_err, r_rdata, acc);
        end
        xfer(1'b1, 8'h04, 32'h00000001);
        total++;
        if (r_err !== 1'b0 || r_tmo !== 1'b0) begin
            bad++; $display("FAIL wr_ctrl: err=%b tmo=%b want 0 0", r_err, r_tmo);
        end
        xfer(1'b0, 8'h08, 32'h0);
        total++;
        if (r_err !== 1'b0 || r_rdata !== 32'h000000F0) begin
            bad++; $display("FAIL rd_result: err=%b rdata=%h want 0 000000f0", r_err, r_rdata);
        end
    endtask

    task automatic test_errors();
        xfer(1'b1, 8'h08, 32'h12345678);
        total++;
        if (r_err !== 1'b1 || r_tmo !== 1'b0 || err_count !== 8'd1) begin
            bad++; $display("FAIL wr_ro: err=%b tmo=%b cnt=%0d want 1 0 1", r_err, r_tmo, err_count);
        end
        xfer(1'b0, 8'h0C, 32'h0);
        total++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0 || err_count !== 8'd2) begin
            bad++; $display("FAIL rd_bad: err=%b rdata=%h cnt=%0d want 1 0 2", r_err, r_rdata, err_count);
        end
    endtask

    task automatic test_timing();
        int n;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL t_idle: cmd_ready=%b want 1", cmd_ready); end
        @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b100 || PADDR !== 8'h00) begin
            bad++; $display("FAIL t_setup: psel/pen/rdy=%b paddr=%h want 100 00", {PSEL, PENABLE, cmd_ready}, PADDR);
        end
        cmd_addr = 8'h04;
        @(negedge PCLK);
        total++;
        if ({PSEL, PENABLE, PREADY} !== 3'b111 || PADDR !== 8'h00 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL t_access: psel/pen/rdy=%b paddr=%h rv=%b want 111 00 0", {PSEL, PENABLE, PREADY}, PADDR, rsp_valid);
        end
        @(negedge PCLK);
        total++;
        if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || rsp_rdata !== 32'h000000F0 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL t_resp: rv=%b psel=%b rdata=%h rdy=%b want 1 0 f0 0", rsp_valid, PSEL, rsp_rdata, cmd_ready);
        end
        @(negedge PCLK);
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 1'b0 || PADDR !== 8'h00) begin
            bad++; $display("FAIL t_ready: rdy=%b rv=%b psel=%b paddr=%h want 1 0 0 00", cmd_ready, rsp_valid, PSEL, PADDR);
        end
        @(negedge PCLK);
        total++;
        if (PSEL !== 1'b1 || PADDR !== 8'h04) begin
            bad++; $display("FAIL t_second: psel=%b paddr=%h want 1 04", PSEL, PADDR);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge PCLK); n++; end
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1) begin
            bad++; $display("FAIL t_second_rsp: rv=%b rdata=%h want 1 00000001", rsp_valid, rsp_rdata);
        end
        @(negedge PCLK);
    endtask

    task automatic test_wait_states();
        delay = 8'd1;
        xfer(1'b0, 8'h00, 32'h0);
        total++;
        if (acc != 2 || r_err !== 1'b0 || r_rdata !== 32'h000000F0) begin
            bad++; $display("FAIL wait1: acc=%0d err=%b rdata=%h want 2 0 f0", acc, r_err, r_rdata);
        end
        delay = 8'd15;
        xfer(1'b0, 8'h04, 32'h0);
        total++;
        if (acc != 16 || r_tmo !== 1'b0 || r_err !== 1'b0 || r_rdata !== 32'h1) begin
            bad++; $display("FAIL wait15_edge: acc=%0d tmo=%b err=%b rdata=%h want 16 0 0 1", acc, r_tmo, r_err, r_rdata);
        end
        delay = 8'd0;
    endtask

    task automatic test_timeout();
        hang = 1'b1;
        xfer(1'b0, 8'h00, 32'h0);
        total++;
        if (acc != 16 || r_err !== 1'b1 || r_tmo !== 1'b1 || r_rdata !== 32'h0 || r_psel !== 1'b0) begin
            bad++; $display("FAIL timeout: acc=%0d err=%b tmo=%b rdata=%h psel=%b want 16 1 1 0 0", acc, r_err, r_tmo, r_rdata, r_psel);
        end
        total++;
        if (err_count !== 8'd3) begin bad++; $display("FAIL timeout_cnt: got %0d want 3", err_count); end
        hang = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 251; i++) xfer(1'b0, 8'h0C, 32'h0);
        total++;
        if (err_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", err_count); end
        for (int i = 0; i < 9; i++) xfer(1'b0, 8'h0C, 32'h0);
        total++;
        if (err_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", err_count); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        hang = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 32'h77;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!(PSEL && PENABLE) && n < 10) begin @(posedge PCLK); #1 n++; end
        #2 PRESETn = 1'b0;
        #1;
        total++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b001 || err_count !== 8'd0) begin
            bad++; $display("FAIL rst_mid: psel/pen/rdy=%b cnt=%0d want 001 0", {PSEL, PENABLE, cmd_ready}, err_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge PCLK); seen |= rsp_valid; end
        hang = 1'b0;
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge PCLK); seen |= rsp_valid; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_rsp: rsp_valid=%b want 0", seen); end
        xfer(1'b1, 8'h00, 32'h000000A5);
        xfer(1'b0, 8'h00, 32'h0);
        total++;
        if (r_rdata !== 32'h000000A5 || r_err !== 1'b0 || err_count !== 8'd0) begin
            bad++; $display("FAIL rst_after: rdata=%h err=%b cnt=%0d want a5 0 0", r_rdata, r_err, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_timing();
        test_wait_states();
        test_timeout();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
